// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and helpers for the single-port memory bank
//
// Purpose: holds the bank FSM state encoding and the address-width helper
//          used by mem_sp_bank and mem_sp_array.

package mem_pkg;

  typedef enum logic {
    MEM_INIT = 1'b0,
    MEM_RUN  = 1'b1
  } mem_state_e;

  // $clog2(1) is 0, which would give a zero-width address bus.
  function automatic int mem_addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_sp_array.sv
// rtl/mem_sp_array.sv - storage array with byte-enabled write and registered read
//
// Purpose: DATA_W x DEPTH storage, no reset. Callers guarantee addr < DEPTH
//          whenever we or re is asserted.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write strobe
//   be     in   byte enables for the write, bit i covers wdata[8i+7:8i]
//   addr   in   word address for read or write
//   wdata  in   write data
//   re     in   read strobe; rdata holds its value while re is low
//   rdata  out  registered read data

module mem_sp_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    // Holding rdata when re is low lets the bank keep a stalled response stable.
    if (re) begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/mem_sp_bank.sv
// rtl/mem_sp_bank.sv - single-port memory bank with request/response handshake
//
// Purpose: valid/ready request channel (read or byte-enabled write), one-cycle
//          registered read response with backpressure, out-of-range detection,
//          and an INIT_VAL sweep over every word after reset.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high reset
//   req_valid  in   request present
//   req_ready  out  request accepted this cycle when req_valid is also high
//   req_we     in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write data
//   req_be     in   write byte enables (ignored on reads)
//   rsp_valid  out  read response present
//   rsp_ready  in   consumer takes the response
//   rsp_rdata  out  read data (0 for out-of-range reads)
//   rsp_err    out  read address was >= DEPTH
//   init_busy  out  init sweep in progress

module mem_sp_bank
  import mem_pkg::*;
#(
  parameter int               DATA_W   = 32,
  parameter int               DEPTH    = 16,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  localparam int              BE_W     = DATA_W / 8,
  localparam int              ADDR_W   = mem_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_busy
);

  mem_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic              r_rsp_sel;   // 1: response data comes from the array

  logic              w_req_ready;
  logic              w_init_busy;
  logic              w_rd_acc;
  logic              w_in_range;
  logic [31:0]       w_addr_ext;

  logic              w_arr_we;
  logic [BE_W-1:0]   w_arr_be;
  logic [ADDR_W-1:0] w_arr_addr;
  logic [DATA_W-1:0] w_arr_wdata;
  logic              w_arr_re;
  logic [DATA_W-1:0] w_arr_rdata;

  assign w_addr_ext = 32'(req_addr);
  assign w_in_range = (w_addr_ext < 32'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MEM_INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_init_busy = 1'b0;
    w_req_ready = 1'b0;
    w_rd_acc    = 1'b0;
    w_arr_we    = 1'b0;
    w_arr_be    = '0;
    w_arr_addr  = req_addr;
    w_arr_wdata = req_wdata;
    w_arr_re    = 1'b0;
    case (r_state)
      MEM_INIT: begin
        w_init_busy = 1'b1;
        w_arr_we    = 1'b1;
        w_arr_be    = '1;
        w_arr_addr  = r_ptr;
        w_arr_wdata = INIT_VAL;
        w_ptr_nxt   = r_ptr + 1'b1;
        if (r_ptr == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = MEM_RUN;
        end
      end
      MEM_RUN: begin
        // Writes stall behind a pending response too, keeping ordering trivial.
        w_req_ready = !r_rsp_valid || rsp_ready;
        w_rd_acc    = req_valid && w_req_ready && !req_we;
        w_arr_we    = req_valid && w_req_ready && req_we && w_in_range;
        w_arr_be    = req_be;
        w_arr_re    = w_rd_acc && w_in_range;
      end
      default: begin
        w_state_nxt = MEM_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_sel   <= 1'b0;
    end else if (w_rd_acc) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= !w_in_range;
      r_rsp_sel   <= w_in_range;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  mem_sp_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (w_arr_we),
    .be    (w_arr_be),
    .addr  (w_arr_addr),
    .wdata (w_arr_wdata),
    .re    (w_arr_re),
    .rdata (w_arr_rdata)
  );

  // The array has no reset, so the response data is forced to 0 until a real
  // in-range read has loaded it, and for out-of-range reads.
  assign rsp_rdata = r_rsp_sel ? w_arr_rdata : '0;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign req_ready = w_req_ready;
  assign init_busy = w_init_busy;

endmodule

// File: tb/tb_mem_sp_bank.sv
// tb/tb_mem_sp_bank.sv - scoreboard bench for mem_sp_bank

module tb_mem_sp_bank;

  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 12;
  localparam logic [31:0] IVAL   = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] model [16];
  logic [32:0] exp_q [$];

  mem_sp_bank #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .INIT_VAL (IVAL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < 16; i++) model[i] = IVAL;
  endtask

  // Scoreboard consumer: every response handshake pops one expectation.
  always @(negedge clk) begin : monitor
    logic [32:0] e;
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", rsp_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e[31:0]);
        check("rsp_err", rsp_err, e[32]);
      end
    end
  end

  // Issue one request and wait (bounded) for it to be accepted.
  task automatic do_req(input bit we, input logic [3:0] addr, input logic [31:0] d,
                        input logic [3:0] be, output int acc_cyc);
    int  waited = 0;
    bit  ok = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = d;
    req_be    = be;
    acc_cyc   = -1;
    while (!ok && waited < 50) begin
      @(negedge clk);
      if (req_ready) ok = 1;
      else waited++;
    end
    if (!ok) begin
      check("req_ready_timeout", req_ready, 1'b1);
      req_valid = 1'b0;
      return;
    end
    if (we) begin
      if (addr < DEPTH) begin
        for (int i = 0; i < 4; i++) if (be[i]) model[addr][8*i +: 8] = d[8*i +: 8];
      end
    end else begin
      exp_q.push_back((addr < DEPTH) ? {1'b0, model[addr]} : {1'b1, 32'h0});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc_cyc   = cyc;
    if (!we) check("rd_latency", rsp_valid, 1'b1);
  endtask

  // Called right after reset deasserts: measures the sweep length and ready rise.
  task automatic sweep_check();
    int busy  = 0;
    int first = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) check("post_rst_rsp_valid", rsp_valid, 1'b0);
      if (init_busy) busy++;
      if (req_ready && first < 0) first = k;
    end
    check("init_busy_cycles", busy, DEPTH);
    check("req_ready_first", first, DEPTH);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int c0, c1, w;
    logic [31:0] snap;

    model_init();
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_init_busy", init_busy, 1'b1);
    reset = 1'b0;
    sweep_check();

    for (int a = 0; a < DEPTH; a++) do_req(0, 4'(a), 32'h0, 4'h0, c0);
    idle(2);

    // Byte enables
    do_req(1, 4'd3, 32'hDEAD_BEEF, 4'b1111, c0);
    do_req(1, 4'd3, 32'h1122_3344, 4'b0101, c0);
    do_req(0, 4'd3, 32'h0, 4'b0000, c0);
    do_req(1, 4'd7, 32'hFFFF_FFFF, 4'b0000, c0);
    do_req(0, 4'd7, 32'h0, 4'b1111, c0);
    idle(2);

    // Back-to-back reads with a 3-cycle consumer stall
    fork
      begin
        do_req(0, 4'd0, 32'h0, 4'h0, c0);
        do_req(0, 4'd1, 32'h0, 4'h0, c0);
        do_req(0, 4'd2, 32'h0, 4'h0, c0);
      end
      begin
        w = 0;
        while (!rsp_valid && w < 20) begin
          @(posedge clk);
          #1;
          w++;
        end
        if (!rsp_valid) check("stall_wait", rsp_valid, 1'b1);
        rsp_ready = 1'b0;
        snap = rsp_rdata;
        repeat (3) begin
          @(negedge clk);
          check("stall_rdata", rsp_rdata, snap);
          check("stall_rsp_valid", rsp_valid, 1'b1);
          check("stall_req_ready", req_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    idle(2);

    // Out of range (DEPTH = 12, 4-bit address)
    do_req(1, 4'd13, 32'h1234_5678, 4'b1111, c0);
    do_req(0, 4'd13, 32'h0, 4'h0, c0);
    do_req(0, 4'd11, 32'h0, 4'h0, c0);
    idle(2);

    // Write then read in the next cycle
    do_req(1, 4'd5, 32'hCAFE_F00D, 4'b1111, c0);
    do_req(0, 4'd5, 32'h0, 4'h0, c1);
    check("wr_rd_gap", c1 - c0, 1);
    idle(2);

    // Reset while a response is stalled, with a request in flight
    rsp_ready = 1'b0;
    do_req(0, 4'd3, 32'h0, 4'h0, c0);
    reset     = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 4'd3;
    req_wdata = 32'h0;
    req_be    = 4'b1111;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    exp_q.delete();
    model_init();
    sweep_check();
    do_req(0, 4'd3, 32'h0, 4'h0, c0);
    idle(3);

    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_sp_bank.md
# mem_sp_bank

Parametrised single-port synchronous memory bank with a valid/ready request channel, byte-enable writes, a registered read-response channel with backpressure, and an automatic post-reset initialisation sweep. It is the general-purpose storage block for datapath units that need more than a fixed 4×8 register file: configurable width and depth, explicit flow control, and out-of-range detection for non-power-of-two depths.

## Interface
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 16, number of words; any value ≥ 2.
- INIT_VAL, '0, word value written to every location during the init sweep.
- Derived (localparam): BE_W = DATA_W/8; ADDR_W = $clog2(DEPTH).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  bank accepts a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  BE_W  byte enables; bit i covers wdata[8i+7:8i].
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  read data.
- rsp_err  out  1  the read address was ≥ DEPTH.
- init_busy  out  1  init sweep in progress.

## Operation
- FSM states: INIT and RUN.
  - reset → INIT, with the sweep pointer set to 0.
  - INIT: write INIT_VAL to mem[ptr] with all bytes enabled, then ptr++. Go to RUN after writing ptr = DEPTH-1.
  - RUN: serve requests. Reset is the only exit from RUN.
- Handshake: a request is accepted when req_valid && req_ready.
  - req_ready = (state == RUN) && (!rsp_valid || rsp_ready).
  - req_ready does not depend on req_valid or req_we.
- Accepted write:
  - mem[addr] byte i ← wdata byte i, for each be[i] = 1. Bytes with be[i] = 0 are unchanged.
  - be = 0 is a legal no-op.
  - A write produces no response.
- Accepted read: the response is registered and appears on the next cycle.
  - rsp_rdata = mem[addr], rsp_err = 0.
  - req_be is ignored on reads.
- Out-of-range address (addr ≥ DEPTH, possible only when DEPTH is not a power of two):
  - write: dropped, no memory change.
  - read: response with rsp_rdata = 0 and rsp_err = 1.
- Response register:
  - Holds rsp_valid, rsp_rdata and rsp_err stable while rsp_valid && !rsp_ready.
  - Clears rsp_valid on a handshake unless a new read is accepted in the same cycle, in which case it reloads.
- Memory has no reset of its own. Initial contents come only from the sweep.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, init_busy 1.
- Init sweep:
  - Starts on the first cycle after reset deasserts and lasts exactly DEPTH cycles.
  - init_busy = 1 and req_ready = 0 throughout.
  - req_ready rises at cycle DEPTH after reset deasserts, provided no response is pending.
- Read latency: 1 cycle. A read accepted in cycle N gives rsp_valid = 1 in cycle N+1.
- Throughput: one request per cycle while rsp_ready = 1.
- Write then read, same address:
  - A write in cycle N followed by a read in cycle N+1 returns the written data.
  - Only one request is accepted per cycle, so there is no same-cycle hazard.
- Stall: with rsp_valid = 1 and rsp_ready = 0, req_ready = 0. Writes also stall, which keeps ordering simple.
- Reset mid-operation (any state, any cycle):
  - Pending response dropped, rsp_valid → 0.
  - In-flight request ignored.
  - Sweep restarts at address 0.

## Structure
- Package mem_pkg holds:
  - the state enum: MEM_INIT, MEM_RUN.
  - a function for the ADDR_W computation that guards DEPTH = 1.
- Sub-module mem_sp_array contains the storage only:
  - DATA_W × DEPTH array.
  - Synchronous byte-enabled write and synchronous read.
  - Ports: clk, we, be, addr, wdata, re, rdata.
  - No reset.
- The top level holds the FSM, the sweep pointer, the range check, the handshake and the response register.

## Test plan
Default configuration: DATA_W=32, DEPTH=12, INIT_VAL=32'hA5A5_A5A5.
- **Init sweep:** release reset, then read addresses 0–11 → init_busy high exactly 12 cycles, req_ready first high in cycle 12, every read returns A5A5_A5A5 with rsp_err = 0.
- **Byte enables:**
  - write addr 3, wdata DEADBEEF, be 4'b1111; then write addr 3, wdata 11223344, be 4'b0101.
  - Read addr 3 → DE22BE44.
- **Back-to-back and stall:**
  - Stream reads of addrs 0, 1, 2 with rsp_ready held 0 for 3 cycles after the first response.
  - Required: rsp_rdata stable during the stall, req_ready = 0 during the stall, all three responses delivered in order with no loss.
- **Out of range:** write addr 13 with data 12345678, then read addr 13 → rsp_rdata 0, rsp_err 1. Read addr 11 → unchanged A5A5_A5A5.
- **Write then read:** write addr 5 = CAFEF00D in cycle N, read addr 5 in cycle N+1 → rsp_valid in cycle N+2 with CAFEF00D.
- **Reset mid-operation:**
  - Assert reset for 1 cycle while a response is stalled.
  - Required: rsp_valid 0 on the next cycle, full 12-cycle sweep repeated, addr 3 reads A5A5_A5A5.
